// File: rtl/x4xx_link_mon_pkg.sv
// Shared types and port_info field layout for the QSFP link monitor.
package x4xx_link_mon_pkg;

    typedef enum logic [1:0] {
        DOWN      = 2'd0,
        UP_PEND   = 2'd1,
        UP        = 2'd2,
        DOWN_PEND = 2'd3
    } link_state_t;

    localparam int PI_FIELD_W     = 8;
    localparam int PI_PORTNUM_LSB = 24;
    localparam int PI_LANE_LSB    = 16;
    localparam int PI_PROTO_LSB   = 8;
    localparam int PI_ACT_BIT     = 1;
    localparam int PI_LINK_BIT    = 0;

endpackage

// File: rtl/x4xx_link_debounce.sv
// Single-lane link-up debouncer: the debounced state flips only after
// DEBOUNCE_CYC consecutive samples disagreeing with it. link_nxt_o exposes
// the value link_up_o takes on the coming edge so the parent can act on
// transitions in the same cycle they become visible.
module x4xx_link_debounce
    import x4xx_link_mon_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1000
) (
    input  logic clk40_i,
    input  logic rst_i,
    input  logic link_up_raw_i,
    output logic link_up_o,
    output logic link_nxt_o
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               DIRECT   = (DEBOUNCE_CYC == 1);

    link_state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             link_q;
    logic             link_d;

    // Next debounced value, derived from the current state and raw sample.
    always_comb begin
        link_d = link_q;
        case (state_q)
            DOWN:      if (link_up_raw_i && DIRECT) link_d = 1'b1;
            UP_PEND:   if (link_up_raw_i && (cnt_q == CNT_LAST)) link_d = 1'b1;
            UP:        if (!link_up_raw_i && DIRECT) link_d = 1'b0;
            DOWN_PEND: if (!link_up_raw_i && (cnt_q == CNT_LAST)) link_d = 1'b0;
            default:   link_d = link_q;
        endcase
    end

    // Debounce FSM with its run-length counter and registered link state.
    always_ff @(posedge clk40_i) begin
        if (rst_i) begin
            state_q <= DOWN;
            cnt_q   <= '0;
            link_q  <= 1'b0;
        end else begin
            link_q <= link_d;
            case (state_q)
                DOWN: begin
                    if (link_up_raw_i) begin
                        if (DIRECT) begin
                            state_q <= UP;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= UP_PEND;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                end
                UP_PEND: begin
                    if (!link_up_raw_i) begin
                        state_q <= DOWN;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= UP;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                UP: begin
                    if (!link_up_raw_i) begin
                        if (DIRECT) begin
                            state_q <= DOWN;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= DOWN_PEND;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                end
                DOWN_PEND: begin
                    if (link_up_raw_i) begin
                        state_q <= UP;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= DOWN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= DOWN;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign link_up_o  = link_q;
    assign link_nxt_o = link_d;

endmodule

// File: rtl/x4xx_qsfp_link_monitor.sv
// Per-lane QSFP link monitor in the clk40 domain: debounced link state,
// LED-length activity stretch, saturating flap counters and port_info words.
// Optional sticky link-change interrupt enabled by X4XX_LINK_MON_IRQ_EN.
module x4xx_qsfp_link_monitor
    import x4xx_link_mon_pkg::*;
#(
    parameter int                     NUM_LANES    = 4,
    parameter logic [7:0]             PORTNUM      = 8'd0,
    parameter logic [8*NUM_LANES-1:0] PROTOCOL     = {NUM_LANES{8'd0}},
    parameter int                     DEBOUNCE_CYC = 1000,
    parameter int                     ACT_HOLD_CYC = 4_000_000,
    parameter int                     FLAP_CNT_W   = 16
) (
    input  logic                             clk40,
    input  logic                             clk40_rst,
    input  logic [NUM_LANES-1:0]             link_up_raw,
    input  logic [NUM_LANES-1:0]             act_pulse,
    input  logic [NUM_LANES-1:0]             cnt_clr,
    output logic [NUM_LANES-1:0]             link_up,
    output logic [NUM_LANES-1:0]             activity,
    output logic [NUM_LANES*FLAP_CNT_W-1:0]  flap_count,
    output logic [NUM_LANES*32-1:0]          port_info,
    input  logic [NUM_LANES-1:0]             irq_ack,
    output logic [NUM_LANES-1:0]             irq_status,
    output logic                             irq
);

    localparam int                    HOLD_W    = $clog2(ACT_HOLD_CYC + 1);
    localparam logic [HOLD_W-1:0]     HOLD_LOAD = HOLD_W'(ACT_HOLD_CYC);
    localparam logic [HOLD_W-1:0]     HOLD_ONE  = HOLD_W'(1);
    localparam logic [FLAP_CNT_W-1:0] FLAP_MAX  = '1;
    localparam logic [FLAP_CNT_W-1:0] FLAP_ONE  = FLAP_CNT_W'(1);

    logic [NUM_LANES-1:0] deb_link;
    logic [NUM_LANES-1:0] deb_nxt;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [HOLD_W-1:0]     hold_q, hold_d;
        logic                  act_q, act_d;
        logic [FLAP_CNT_W-1:0] flap_q, flap_d;
        logic [31:0]           info_q, info_d;
        logic                  fall;

        x4xx_link_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_debounce (
            .clk40_i       (clk40),
            .rst_i         (clk40_rst),
            .link_up_raw_i (link_up_raw[i]),
            .link_up_o     (deb_link[i]),
            .link_nxt_o    (deb_nxt[i])
        );

        assign fall = deb_link[i] & ~deb_nxt[i];

        // Next-state for activity hold, flap count and port_info of this lane.
        always_comb begin
            hold_d = hold_q;
            if (!deb_nxt[i]) begin
                hold_d = '0;
            end else if (act_pulse[i] && deb_link[i]) begin
                hold_d = HOLD_LOAD;
            end else if (hold_q != '0) begin
                hold_d = hold_q - HOLD_ONE;
            end
            act_d = (hold_d != '0);

            flap_d = flap_q;
            if (cnt_clr[i]) begin
                flap_d = fall ? FLAP_ONE : '0;
            end else if (fall && (flap_q != FLAP_MAX)) begin
                flap_d = flap_q + FLAP_ONE;
            end

            info_d                                 = '0;
            info_d[PI_PORTNUM_LSB +: PI_FIELD_W]   = PORTNUM;
            info_d[PI_LANE_LSB +: PI_FIELD_W]      = 8'(i);
            info_d[PI_PROTO_LSB +: PI_FIELD_W]     = PROTOCOL[8*i +: 8];
            info_d[PI_ACT_BIT]                     = act_d;
            info_d[PI_LINK_BIT]                    = deb_nxt[i];
        end

        // Lane status registers; port_info status bits track the outputs exactly.
        always_ff @(posedge clk40) begin
            if (clk40_rst) begin
                hold_q <= '0;
                act_q  <= 1'b0;
                flap_q <= '0;
                info_q <= '0;
            end else begin
                hold_q <= hold_d;
                act_q  <= act_d;
                flap_q <= flap_d;
                info_q <= info_d;
            end
        end

        assign activity[i]                              = act_q;
        assign flap_count[FLAP_CNT_W*i +: FLAP_CNT_W]   = flap_q;
        assign port_info[32*i +: 32]                    = info_q;
    end

    assign link_up = deb_link;

`ifdef X4XX_LINK_MON_IRQ_EN
    logic [NUM_LANES-1:0] irq_status_q, irq_status_d;
    logic                 irq_q;

    // A new link change outranks an acknowledge arriving in the same cycle.
    assign irq_status_d = (irq_status_q & ~irq_ack) | (deb_link ^ deb_nxt);

    // Sticky per-lane status and the registered summary interrupt.
    always_ff @(posedge clk40) begin
        if (clk40_rst) begin
            irq_status_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            irq_status_q <= irq_status_d;
            irq_q        <= |irq_status_q;
        end
    end

    assign irq_status = irq_status_q;
    assign irq        = irq_q;
`else
    logic unused_irq_ack;

    assign unused_irq_ack = ^irq_ack;
    assign irq_status     = '0;
    assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_x4xx_qsfp_link_monitor.sv
// Directed bench for x4xx_qsfp_link_monitor (4-lane main instance plus
// 1-lane and 8-lane instances). Build with or without X4XX_LINK_MON_IRQ_EN.
module tb_x4xx_qsfp_link_monitor;

`ifdef X4XX_LINK_MON_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance: 4 lanes, short debounce/hold, 2-bit flap counters.
    logic [3:0]   raw, act, clr, ack;
    logic [3:0]   link_up, activity, irq_st;
    logic [7:0]   flap;
    logic [127:0] pinfo;
    logic         irq;

    x4xx_qsfp_link_monitor #(
        .NUM_LANES    (4),
        .PORTNUM      (8'hA5),
        .PROTOCOL     ({8'h44, 8'h33, 8'h22, 8'h11}),
        .DEBOUNCE_CYC (4),
        .ACT_HOLD_CYC (10),
        .FLAP_CNT_W   (2)
    ) dut (
        .clk40       (clk),
        .clk40_rst   (rst),
        .link_up_raw (raw),
        .act_pulse   (act),
        .cnt_clr     (clr),
        .link_up     (link_up),
        .activity    (activity),
        .flap_count  (flap),
        .port_info   (pinfo),
        .irq_ack     (ack),
        .irq_status  (irq_st),
        .irq         (irq)
    );

    // Single-lane instance with minimum debounce and hold.
    logic        raw1, act1, clr1, ack1;
    logic        lu1, ao1, is1, irq1;
    logic [15:0] fc1;
    logic [31:0] pi1;

    x4xx_qsfp_link_monitor #(
        .NUM_LANES    (1),
        .PORTNUM      (8'h01),
        .PROTOCOL     (8'h7E),
        .DEBOUNCE_CYC (1),
        .ACT_HOLD_CYC (1)
    ) dut1 (
        .clk40       (clk),
        .clk40_rst   (rst),
        .link_up_raw (raw1),
        .act_pulse   (act1),
        .cnt_clr     (clr1),
        .link_up     (lu1),
        .activity    (ao1),
        .flap_count  (fc1),
        .port_info   (pi1),
        .irq_ack     (ack1),
        .irq_status  (is1),
        .irq         (irq1)
    );

    // Eight-lane instance with default timing.
    logic [7:0]   in8;
    logic [7:0]   lu8, ao8, is8;
    logic [127:0] fc8;
    logic [255:0] pi8;
    logic         irq8;

    x4xx_qsfp_link_monitor #(
        .NUM_LANES (8),
        .PORTNUM   (8'h3C)
    ) dut8 (
        .clk40       (clk),
        .clk40_rst   (rst),
        .link_up_raw (in8),
        .act_pulse   (in8),
        .cnt_clr     (in8),
        .link_up     (lu8),
        .activity    (ao8),
        .flap_count  (fc8),
        .port_info   (pi8),
        .irq_ack     (in8),
        .irq_status  (is8),
        .irq         (irq8)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [1:0] flap_exp [0:4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        flap_exp[0] = 2'd1; flap_exp[1] = 2'd2; flap_exp[2] = 2'd3;
        flap_exp[3] = 2'd3; flap_exp[4] = 2'd3;
        rst = 1'b1; raw = '0; act = '0; clr = '0; ack = '0;
        raw1 = 1'b0; act1 = 1'b0; clr1 = 1'b0; ack1 = 1'b0; in8 = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_link", link_up, 4'h0);
        chk("rst_act", activity, 4'h0);
        chk("rst_flap", flap, 8'h0);
        chk("rst_pinfo_lo", pinfo[63:0], 64'h0);
        chk("rst_pinfo_hi", pinfo[127:64], 64'h0);
        chk("rst_irqst", irq_st, 4'h0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_pi1", pi1, 32'h0);

        // Constant port_info fields after release
        rst = 1'b0;
        tick();
        chk("pi_lane0", pinfo[31:0], 32'hA500_1100);
        chk("pi_lane1", pinfo[63:32], 32'hA501_2200);
        chk("pi_lane3", pinfo[127:96], 32'hA503_4400);
        chk("pi1_const", pi1, 32'h0100_7E00);
        chk("pi8_lane5", pi8[32*5 +: 32], 32'h3C05_0000);
        chk("pi8_lane7", pi8[255:224], 32'h3C07_0000);

        // Debounce rise: 4th high sample raises link_up
        raw = 4'b0001; raw1 = 1'b1;
        tick();
        chk("dc1_rise", lu1, 1'b1);
        chk("dc1_pinfo", pi1, 32'h0100_7E01);
        chk("rise_s1", link_up, 4'h0);
        tick(); tick();
        chk("rise_s3", link_up, 4'h0);
        tick();
        chk("rise_s4", link_up, 4'b0001);
        chk("rise_pinfo", pinfo[31:0], 32'hA500_1101);
        chk("rise_irqst", irq_st, IRQ_ON ? 4'b0001 : 4'b0000);

        // One-cycle hold on the single-lane instance
        act1 = 1'b1; tick(); act1 = 1'b0;
        chk("dc1_act_on", ao1, 1'b1);
        tick();
        chk("dc1_act_off", ao1, 1'b0);

        // Activity stretch: 10 cycles
        act = 4'b0001; tick(); act = '0;
        chk("act_c1", activity, 4'b0001);
        chk("act_pinfo", pinfo[31:0], 32'hA500_1103);
        repeat (9) tick();
        chk("act_c10", activity, 4'b0001);
        tick();
        chk("act_c11", activity, 4'b0000);

        // Retrigger at cycle 6 extends to cycle 16
        act = 4'b0001; tick(); act = '0;
        repeat (4) tick();
        act = 4'b0001; tick(); act = '0;
        repeat (9) tick();
        chk("retrig_c15", activity, 4'b0001);
        tick();
        chk("retrig_c16", activity, 4'b0000);

        // Link drop mid-hold clears activity with the fall
        act = 4'b0001; tick(); act = '0;
        raw = 4'b0000;
        repeat (3) tick();
        chk("drop_link_pend", link_up, 4'b0001);
        chk("drop_act_pend", activity, 4'b0001);
        tick();
        chk("drop_link", link_up, 4'b0000);
        chk("drop_act", activity, 4'b0000);
        chk("drop_flap", flap[1:0], 2'd1);
        chk("drop_pinfo", pinfo[31:0], 32'hA500_1100);

        // Glitch rejection with lane 0 up
        raw = 4'b0001;
        repeat (4) tick();
        chk("glitch_up", link_up, 4'b0001);
        ack = 4'hF; tick(); ack = '0;
        chk("glitch_ack", irq_st, 4'h0);
        tick();
        chk("glitch_irq0", irq, 1'b0);
        raw = 4'b0000;
        repeat (3) tick();
        chk("glitch_low3", link_up, 4'b0001);
        raw = 4'b0001;
        repeat (5) tick();
        chk("glitch_link", link_up, 4'b0001);
        chk("glitch_flap", flap[1:0], 2'd1);
        chk("glitch_irqst", irq_st, 4'h0);
        chk("glitch_irq", irq, 1'b0);

        // Flap saturation on lane 1
        for (int k = 0; k < 5; k++) begin
            raw[1] = 1'b1;
            repeat (4) tick();
            raw[1] = 1'b0;
            repeat (4) tick();
            chk($sformatf("flap_sat%0d", k), flap[3:2], flap_exp[k]);
        end

        // Clear coinciding with a fall counts the fall
        raw[1] = 1'b1;
        repeat (4) tick();
        raw[1] = 1'b0;
        repeat (3) tick();
        clr[1] = 1'b1; tick(); clr = '0;
        chk("clr_fall", flap[3:2], 2'd1);
        clr[1] = 1'b1; tick(); clr = '0;
        chk("clr_alone", flap[3:2], 2'd0);
        chk("clr_lane0", flap[1:0], 2'd1);

        // Interrupt on lane 2
        ack = 4'hF; tick(); ack = '0;
        tick();
        chk("irq_idle", irq, 1'b0);
        raw[2] = 1'b1;
        repeat (4) tick();
        chk("irq_rise_link", link_up[2], 1'b1);
        chk("irq_rise_st", irq_st, IRQ_ON ? 4'b0101 & 4'b0100 : 4'b0000);
        chk("irq_rise_lag", irq, 1'b0);
        tick();
        chk("irq_rise_irq", irq, IRQ_ON);
        raw[2] = 1'b0;
        repeat (3) tick();
        ack[2] = 1'b1; tick(); ack = '0;
        chk("irq_fall_link", link_up[2], 1'b0);
        chk("irq_setwins", irq_st[2], IRQ_ON);
        ack[2] = 1'b1; tick(); ack = '0;
        chk("irq_ack_clr", irq_st, 4'h0);
        tick();
        chk("irq_ack_irq", irq, 1'b0);

        // Reset while lane 3 is pending with count 3
        raw[3] = 1'b1;
        repeat (3) tick();
        chk("pend_link", link_up[3], 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mrst_link", link_up, 4'h0);
        chk("mrst_act", activity, 4'h0);
        chk("mrst_flap", flap, 8'h0);
        chk("mrst_pinfo_lo", pinfo[63:0], 64'h0);
        chk("mrst_pinfo_hi", pinfo[127:64], 64'h0);
        chk("mrst_irqst", irq_st, 4'h0);
        chk("mrst_irq", irq, 1'b0);
        chk("mrst_lu1", lu1, 1'b0);
        repeat (3) tick();
        chk("mrst_s3", link_up, 4'h0);
        tick();
        chk("mrst_s4", link_up, 4'b1001);
        chk("mrst_pinfo3", pinfo[127:96], 32'hA503_4401);
        chk("mrst_irqst_up", irq_st, IRQ_ON ? 4'b1001 : 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
